ps2_kbd_controller: RTL
=======================

Name: ps2_kbd_controller

Overview:
- Sits directly downstream of the PS/2 host line engine and consumes its receive byte stream.
- Buffers received scancodes in a FIFO for the CPU-side keyboard port.
- Sequences host-to-device command bytes through the engine's start_tx/tx_busy/tx_complete handshake.
- Handles device ACK (0xFA) and RESEND (0xFE) responses, with retry and timeout.

Parameters:
- clkf, 50000000, system clock frequency in Hz.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2.
- ACK_TIMEOUT_MS, 20, ms allowed from tx_complete to the device response.
- MAX_RETRY, 3, resends attempted after the first transmission before failing.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_rx  in  8  received byte from the line engine
- ps2_rx_valid  in  1  one-cycle strobe; ps2_rx is valid
- ps2_error  in  1  parity error for the byte strobed by ps2_rx_valid
- ps2_start_tx  out  1  one-cycle request to the engine to transmit ps2_tx
- ps2_tx  out  8  byte to transmit
- ps2_tx_busy  in  1  engine transmit in progress
- ps2_tx_complete  in  1  one-cycle strobe; device acknowledged the line-level frame
- rd_data  out  8  head of the receive FIFO
- rd_valid  out  1  FIFO not empty
- rd_ack  in  1  pop the head entry
- cmd_data  in  8  command byte
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_done  out  1  one-cycle strobe; device ACKed the command
- cmd_fail  out  1  one-cycle strobe; retries exhausted or timeout
- overflow  out  1  sticky; a byte was lost to a full FIFO
- err_count  out  8  saturating count of parity-error bytes

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high; all state is assigned on posedge clk when reset=1.
- Reset values: rd_valid=0, rd_data=0, ps2_start_tx=0, ps2_tx=0, cmd_ready=1, cmd_done=0, cmd_fail=0, overflow=0, err_count=0. FIFO empty, retry count 0, state IDLE.
- Reset mid-command abandons the command with no done/fail strobe.
- Receive path, on ps2_rx_valid:
  - ps2_error=1: byte dropped; err_count increments, saturating at 255.
  - Else, state WAIT_ACK and byte 0xFA or 0xFE: consumed by the command FSM, not pushed.
  - Else: byte pushed to the FIFO.
- FIFO:
  - rd_data shows the head combinationally from storage; rd_valid = (count != 0).
  - rd_ack with rd_valid pops. rd_ack when empty is ignored.
  - Push and pop in the same cycle both succeed, even when full; count unchanged.
  - Push when full and no pop: byte discarded, overflow set. overflow clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Command FSM states:
  - IDLE: cmd_ready=1. cmd_valid latches cmd_data into ps2_tx, clears the retry count, goes to SEND.
  - SEND: if ps2_tx_busy=0, assert ps2_start_tx for exactly one cycle and go to WAIT_TX; otherwise hold.
  - WAIT_TX: ps2_tx_complete goes to WAIT_ACK and loads the timeout counter with (clkf/1000)*ACK_TIMEOUT_MS.
  - WAIT_ACK, checked in this priority order:
    - valid 0xFA: cmd_done pulse, go to IDLE.
    - valid 0xFE with retry < MAX_RETRY: retry++, go to SEND, same byte.
    - valid 0xFE with retry = MAX_RETRY: cmd_fail pulse, go to IDLE.
    - counter reaches 0: cmd_fail pulse, go to IDLE.
    - otherwise counter decrements each cycle.
- cmd_valid outside IDLE is ignored; the requester holds it until it sees cmd_ready.
- Latency:
  - rx strobe to rd_valid: 1 cycle.
  - cmd_valid to ps2_start_tx: 2 cycles when the engine is idle.
  - 0xFA strobe to cmd_done: 1 cycle.
- Non-ACK bytes arriving during WAIT_TX or WAIT_ACK are pushed normally, so scancodes interleaved with a command are preserved.

Optional Feature:
- Macro: PS2_OVERRUN_MARK_EN.
- Defined: a push attempt when full overwrites the most recently written entry with 0x00, the PS/2 set-2 overrun code, so software sees the loss in-stream. overflow is still set. Further lost bytes do not rewrite the marker while the FIFO stays full.
- Undefined: lost bytes are silently discarded; only overflow records the loss.

Test Plan:
- Push 0x1C then 0xF0,0x1C with no errors; pop with rd_ack -> rd_data reads 0x1C, 0xF0, 0x1C; rd_valid=0 after the third pop.
- Byte 0x55 with ps2_error=1 -> FIFO unchanged, err_count=1. 256 such bytes -> err_count holds 255.
- cmd 0xED; engine pulses tx_complete; rx 0xFA 1000 cycles later -> single ps2_start_tx pulse, cmd_done pulse, FIFO empty, cmd_ready=1.
- cmd 0xFF; device answers 0xFE four times (MAX_RETRY=3) -> four ps2_start_tx pulses each with ps2_tx=0xFF, then cmd_fail.
- cmd 0xF4, no response for 1,000,000 cycles (clkf=50e6, 20 ms) -> cmd_fail exactly one cycle after the counter expires. Scancode 0x2A arriving during WAIT_ACK -> lands in the FIFO.
- Fill with 16 bytes 0x01..0x10, push 0x11 -> overflow=1. Without the macro, FIFO reads 0x01..0x10; with PS2_OVERRUN_MARK_EN, the last entry reads 0x00. Push and pop in the same cycle when full -> count stays 16, overflow not set.

Source files
------------

// File: rtl/ps2_kbd_controller.sv
// PS/2 keyboard controller: receive scancode FIFO plus host-to-device command sequencer with ACK/RESEND retry and timeout.
// Optional macro PS2_OVERRUN_MARK_EN: an overflowing push stamps 0x00 into the newest FIFO entry.
module ps2_kbd_controller #(
   parameter int unsigned clkf           = 50000000,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned ACK_TIMEOUT_MS = 20,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ps2_rx,
   input  logic       ps2_rx_valid,
   input  logic       ps2_error,
   output logic       ps2_start_tx,
   output logic [7:0] ps2_tx,
   input  logic       ps2_tx_busy,
   input  logic       ps2_tx_complete,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ack,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       cmd_done,
   output logic       cmd_fail,
   output logic       overflow,
   output logic [7:0] err_count
);

   localparam int unsigned AW           = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned RW           = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [AW:0] DEPTH        = (AW + 1)'(FIFO_DEPTH);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
   localparam logic [31:0] TIMEOUT_LOAD = 32'((clkf / 1000) * ACK_TIMEOUT_MS);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_TX,
      WAIT_ACK
   } state_t;

   state_t          state;
   logic [RW-1:0]   retry;
   logic [31:0]     timer;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   logic rx_good;
   logic rx_is_ack;
   logic rx_is_resend;
   logic rx_is_resp;
   logic push;
   logic pop;
   logic full;
   logic push_ok;

   always_comb begin
      rx_good      = ps2_rx_valid && !ps2_error;
      rx_is_ack    = rx_good && (ps2_rx == 8'hFA);
      rx_is_resend = rx_good && (ps2_rx == 8'hFE);
      rx_is_resp   = (state == WAIT_ACK) && (rx_is_ack || rx_is_resend);
      push         = rx_good && !rx_is_resp;
      pop          = rd_ack && (count != '0);
      full         = (count == DEPTH);
      push_ok      = push && (!full || pop);
   end

   assign rd_data  = mem[rd_ptr];
   assign rd_valid = (count != '0);

   // When full, a simultaneous pop frees the slot the push lands in, so both proceed.
`ifdef PS2_OVERRUN_MARK_EN
   logic mark_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem       <= '{default: '0};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         mark_done <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= ps2_rx;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            mark_done <= 1'b0;
         end
         if (push_ok && !pop)
            count <= count + (AW + 1)'(1);
         else if (pop && !push_ok)
            count <= count - (AW + 1)'(1);
         if (push && full && !pop) begin
            overflow <= 1'b1;
            if (!mark_done) begin
               mem[wr_ptr - AW'(1)] <= 8'h00;
               mark_done            <= 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         mem      <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= ps2_rx;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)
            count <= count + (AW + 1)'(1);
         else if (pop && !push_ok)
            count <= count - (AW + 1)'(1);
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (ps2_rx_valid && ps2_error && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         ps2_start_tx <= 1'b0;
         ps2_tx       <= '0;
         cmd_ready    <= 1'b1;
         cmd_done     <= 1'b0;
         cmd_fail     <= 1'b0;
         retry        <= '0;
         timer        <= '0;
      end else begin
         ps2_start_tx <= 1'b0;
         cmd_done     <= 1'b0;
         cmd_fail     <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  ps2_tx    <= cmd_data;
                  retry     <= '0;
                  cmd_ready <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (!ps2_tx_busy) begin
                  ps2_start_tx <= 1'b1;
                  state        <= WAIT_TX;
               end
            end
            WAIT_TX: begin
               if (ps2_tx_complete) begin
                  timer <= TIMEOUT_LOAD;
                  state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (rx_is_ack) begin
                  cmd_done  <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else if (rx_is_resend && (retry < RETRY_MAX)) begin
                  retry <= retry + RW'(1);
                  state <= SEND;
               end else if (rx_is_resend || (timer == '0)) begin
                  cmd_fail  <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
